// File: rtl/ext_trig_pkg.sv
// Shared types for the multi-channel external trigger conditioner.
// Trigger type and hold-off state encodings, sync depth, edge select.
package ext_trig_pkg;

  typedef enum logic [1:0] {
    TRG_RISE,
    TRG_FALL,
    TRG_BOTH,
    TRG_RSVD
  } trig_type_e;

  typedef enum logic {
    HS_IDLE,
    HS_HOLD
  } hold_state_e;

  localparam int SYNC_STAGES = 2;

  function automatic logic type_hit(
    input trig_type_e t,
    input logic       rise,
    input logic       fall
  );
    logic hit;
    hit = 1'b0;
    unique case (t)
      TRG_RISE: hit = rise;
      TRG_FALL: hit = fall;
      TRG_BOTH: hit = rise | fall;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ext_trig_ch.sv
// One trigger channel: synchroniser, glitch filter, priming,
// edge select and hold-off dead-time FSM.
module ext_trig_ch
  import ext_trig_pkg::*;
#(
  parameter int unsigned FILT_LEN  = 4,
  parameter int unsigned HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pin,
  input  logic                 en,
  input  logic [1:0]           ttype,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic                 pulse
);

  localparam int unsigned VW = SYNC_STAGES + FILT_LEN;
  localparam logic [HOLDOFF_W-1:0] H_ONE = 1;

  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [FILT_LEN-1:0]    filt_q, filt_d;
  logic [VW-1:0]          vld_q, vld_d;
  logic                   stat_q, stat_d;
  logic                   stat_dly_q, stat_dly_d;
  logic                   primed_q, primed_d;
  hold_state_e            state_q, state_d;
  logic [HOLDOFF_W-1:0]   cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;

  logic all_hi, all_lo, settled;
  logic rise, fall, hit;

  // Sync chain, filter window and fill tracking;
  // the first settled window only primes the level.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pin};
    filt_d     = {filt_q[FILT_LEN-2:0],
                  sync_q[SYNC_STAGES-1]};
    vld_d      = {vld_q[VW-2:0], 1'b1};
    all_hi     = &filt_q;
    all_lo     = ~|filt_q;
    settled    = vld_q[VW-1] & (all_hi | all_lo);
    stat_d     = stat_q;
    primed_d   = primed_q;
    stat_dly_d = stat_q;
    if (settled) begin
      stat_d = all_hi;
      if (!primed_q) begin
        primed_d   = 1'b1;
        stat_dly_d = all_hi;
      end
    end
  end

  // Edge select and hold-off dead-time state machine.
  always_comb begin
    rise    = primed_q & stat_q & ~stat_dly_q;
    fall    = primed_q & ~stat_q & stat_dly_q;
    hit     = type_hit(trig_type_e'(ttype), rise, fall);
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      HS_IDLE: begin
        if (hit && en) begin
          pulse_d = 1'b1;
          if (holdoff != '0) begin
            cnt_d   = holdoff;
            state_d = HS_HOLD;
          end
        end
      end
      HS_HOLD: begin
        cnt_d = cnt_q - H_ONE;
        if (cnt_q == H_ONE) begin
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      filt_q     <= '0;
      vld_q      <= '0;
      stat_q     <= 1'b0;
      stat_dly_q <= 1'b0;
      primed_q   <= 1'b0;
      state_q    <= HS_IDLE;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      filt_q     <= filt_d;
      vld_q      <= vld_d;
      stat_q     <= stat_d;
      stat_dly_q <= stat_dly_d;
      primed_q   <= primed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/ext_trig_mc.sv
// Multi-channel trigger conditioner top: channel array, trigger-any,
// event counter; EXT_TRIG_TIMESTAMP_EN adds a timestamp latch.
module ext_trig_mc
  import ext_trig_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned FILT_LEN  = 4,
  parameter int unsigned HOLDOFF_W = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ext_trg_in,
  input  logic [NUM_CH-1:0]     ctrl_enable,
  input  logic [2*NUM_CH-1:0]   ctrl_trigger_type,
  input  logic [HOLDOFF_W-1:0]  ctrl_holdoff,
  input  logic                  ctrl_cnt_clr,
  output logic [NUM_CH-1:0]     ext_trg_out,
  output logic                  trg_any,
  output logic [CNT_W-1:0]      trg_cnt
`ifdef EXT_TRIG_TIMESTAMP_EN
  ,
  input  logic [63:0]           ts_now,
  output logic [63:0]           ts_latched,
  output logic                  ts_valid,
  output logic [NUM_CH-1:0]     ts_chmask
`endif
);

  localparam logic [CNT_W-1:0] C_ONE = 1;

  logic [CNT_W-1:0] trg_cnt_q, trg_cnt_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ext_trig_ch #(
      .FILT_LEN  (FILT_LEN),
      .HOLDOFF_W (HOLDOFF_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin     (ext_trg_in[i]),
      .en      (ctrl_enable[i]),
      .ttype   (ctrl_trigger_type[2*i +: 2]),
      .holdoff (ctrl_holdoff),
      .pulse   (ext_trg_out[i])
    );
  end

  assign trg_any = |ext_trg_out;

  // Event counter: one count per trigger cycle, clear wins.
  always_comb begin
    trg_cnt_d = trg_cnt_q;
    if (ctrl_cnt_clr) begin
      trg_cnt_d = '0;
    end else if (trg_any) begin
      trg_cnt_d = trg_cnt_q + C_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trg_cnt_q <= '0;
    end else begin
      trg_cnt_q <= trg_cnt_d;
    end
  end

  assign trg_cnt = trg_cnt_q;

`ifdef EXT_TRIG_TIMESTAMP_EN
  logic [63:0]       ts_lat_q, ts_lat_d;
  logic              ts_vld_q, ts_vld_d;
  logic [NUM_CH-1:0] ts_msk_q, ts_msk_d;

  // Capture time and channel mask of each trigger cycle.
  always_comb begin
    ts_lat_d = ts_lat_q;
    ts_msk_d = ts_msk_q;
    ts_vld_d = trg_any;
    if (trg_any) begin
      ts_lat_d = ts_now;
      ts_msk_d = ext_trg_out;
    end
  end

  // Timestamp registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_lat_q <= '0;
      ts_vld_q <= 1'b0;
      ts_msk_q <= '0;
    end else begin
      ts_lat_q <= ts_lat_d;
      ts_vld_q <= ts_vld_d;
      ts_msk_q <= ts_msk_d;
    end
  end

  assign ts_latched = ts_lat_q;
  assign ts_valid   = ts_vld_q;
  assign ts_chmask  = ts_msk_q;
`endif

endmodule

// File: tb/tb_ext_trig_mc.sv
// Bench for ext_trig_mc: directed scenarios plus random pins/controls
// checked every cycle against a window-based event model.
module tb_ext_trig_mc;

  localparam int NUM_CH = 4;
  localparam int FILT_LEN = 4;
  localparam int HOLDOFF_W = 16;
  localparam int CNT_W = 6;
  localparam int WIN = FILT_LEN + 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_CH-1:0]    ext_trg_in;
  logic [NUM_CH-1:0]    ctrl_enable;
  logic [2*NUM_CH-1:0]  ctrl_trigger_type;
  logic [HOLDOFF_W-1:0] ctrl_holdoff;
  logic                 ctrl_cnt_clr;
  logic [NUM_CH-1:0]    ext_trg_out;
  logic                 trg_any;
  logic [CNT_W-1:0]     trg_cnt;
`ifdef EXT_TRIG_TIMESTAMP_EN
  logic [63:0]          ts_now;
  logic [63:0]          ts_latched;
  logic                 ts_valid;
  logic [NUM_CH-1:0]    ts_chmask;
`endif

  ext_trig_mc #(
    .NUM_CH    (NUM_CH),
    .FILT_LEN  (FILT_LEN),
    .HOLDOFF_W (HOLDOFF_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ext_trg_in        (ext_trg_in),
    .ctrl_enable       (ctrl_enable),
    .ctrl_trigger_type (ctrl_trigger_type),
    .ctrl_holdoff      (ctrl_holdoff),
    .ctrl_cnt_clr      (ctrl_cnt_clr),
    .ext_trg_out       (ext_trg_out),
    .trg_any           (trg_any),
    .trg_cnt           (trg_cnt)
`ifdef EXT_TRIG_TIMESTAMP_EN
    ,
    .ts_now            (ts_now),
    .ts_latched        (ts_latched),
    .ts_valid          (ts_valid),
    .ts_chmask         (ts_chmask)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int pc [NUM_CH];
  int p2q [$];

  bit mq [NUM_CH][$];
  bit mlvl [NUM_CH];
  bit mprim [NUM_CH];
  int mev [NUM_CH];
  int mfree [NUM_CH];
  logic [NUM_CH-1:0] eout;
  logic [CNT_W-1:0]  ecnt;
  logic [63:0]       ets;
  logic [NUM_CH-1:0] emask;
  logic              evld;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic bit type_ok(input int ev, input logic [1:0] t);
    if (ev == 1) return (t == 2'd0) || (t == 2'd2);
    if (ev == 2) return (t == 2'd1) || (t == 2'd2);
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [NUM_CH-1:0] old;
    bit a1, a0, acc;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mq[c].delete();
        mlvl[c] = 1'b0;
        mprim[c] = 1'b0;
        mev[c] = 0;
        mfree[c] = 0;
      end
      eout = '0;
      ecnt = '0;
      ets = '0;
      emask = '0;
      evld = 1'b0;
      return;
    end
    old = eout;
    evld = |old;
    if (|old) begin
`ifdef EXT_TRIG_TIMESTAMP_EN
      ets = ts_now;
`endif
      emask = old;
    end
    if (ctrl_cnt_clr) ecnt = '0;
    else if (|old) ecnt = ecnt + 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      acc = type_ok(mev[c], ctrl_trigger_type[2*c +: 2])
            && ctrl_enable[c] && (cyc >= mfree[c]);
      eout[c] = acc;
      if (acc) mfree[c] = cyc + int'(ctrl_holdoff) + 1;
      mev[c] = 0;
      if (mq[c].size() == WIN) begin
        a1 = 1'b1;
        a0 = 1'b1;
        for (int i = 0; i < FILT_LEN; i++) begin
          if (mq[c][i]) a0 = 1'b0;
          else a1 = 1'b0;
        end
        if (a1 || a0) begin
          if (!mprim[c]) begin
            mprim[c] = 1'b1;
            mlvl[c] = a1;
          end else if (mlvl[c] != a1) begin
            mev[c] = a1 ? 1 : 2;
            mlvl[c] = a1;
          end
        end
      end
      mq[c].push_back(ext_trg_in[c]);
      if (mq[c].size() > WIN) void'(mq[c].pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("out", 64'(ext_trg_out), 64'(eout));
    chk("any", 64'(trg_any), 64'(|eout));
    chk("cnt", 64'(trg_cnt), 64'(ecnt));
`ifdef EXT_TRIG_TIMESTAMP_EN
    chk("ts_valid", 64'(ts_valid), 64'(evld));
    chk("ts_lat", ts_latched, ets);
    chk("ts_mask", 64'(ts_chmask), 64'(emask));
    ts_now = 64'(cyc);
`endif
    for (int c = 0; c < NUM_CH; c++)
      if (ext_trg_out[c]) pc[c]++;
    if (ext_trg_out[2]) p2q.push_back(cyc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int base, first, tot;

  initial begin
    for (int c = 0; c < NUM_CH; c++) pc[c] = 0;
`ifdef EXT_TRIG_TIMESTAMP_EN
    ts_now = '0;
`endif
    rst_n = 1'b0;
    ext_trg_in = 4'b0001;
    ctrl_enable = 4'hF;
    ctrl_trigger_type = 8'h00;
    ctrl_holdoff = '0;
    ctrl_cnt_clr = 1'b0;
    ticks(3);
    chk("rst_out", 64'(ext_trg_out), 64'd0);
    chk("rst_cnt", 64'(trg_cnt), 64'd0);
    rst_n = 1'b1;
    ticks(20);
    chk("prime_nopulse", 64'(pc[0]), 64'd0);

    ext_trg_in[0] = 1'b0;
    ticks(12);
    ctrl_cnt_clr = 1'b1;
    tick();
    ctrl_cnt_clr = 1'b0;
    base = pc[0];
    first = 0;
    ext_trg_in[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (ext_trg_out[0] && first == 0) first = j;
    end
    chk("latency", 64'(first), 64'd8);
    chk("width", 64'(pc[0] - base), 64'd1);
    chk("cnt_one", 64'(trg_cnt), 64'd1);

    ctrl_trigger_type = 8'b00_00_10_00;
    base = pc[1];
    ext_trg_in[1] = 1'b1;
    ticks(3);
    ext_trg_in[1] = 1'b0;
    ticks(12);
    chk("glitch", 64'(pc[1] - base), 64'd0);
    ext_trg_in[1] = 1'b1;
    ticks(4);
    ext_trg_in[1] = 1'b0;
    ticks(16);
    chk("rise_fall", 64'(pc[1] - base), 64'd2);

    ctrl_trigger_type = 8'b00_10_10_00;
    ctrl_holdoff = 16'd10;
    p2q.delete();
    for (int t = 0; t < 4; t++) begin
      ext_trg_in[2] = ~ext_trg_in[2];
      ticks(6);
    end
    ticks(20);
    chk("hold_n", 64'(p2q.size()), 64'd2);
    if (p2q.size() == 2)
      chk("hold_gap", 64'(p2q[1] - p2q[0] >= 11), 64'd1);

    ctrl_holdoff = '0;
    ctrl_trigger_type = 8'h00;
    ext_trg_in = 4'b0000;
    ticks(12);
    ctrl_cnt_clr = 1'b1;
    tick();
    ctrl_cnt_clr = 1'b0;
    ext_trg_in = 4'b1001;
    ticks(12);
    chk("pair_cnt", 64'(trg_cnt), 64'd1);
`ifdef EXT_TRIG_TIMESTAMP_EN
    chk("pair_mask", 64'(ts_chmask), 64'h9);
`endif
    ext_trg_in = 4'b0000;
    ticks(12);
    ext_trg_in = 4'b1001;
    ticks(7);
    ctrl_cnt_clr = 1'b1;
    tick();
    chk("pair_any", 64'(trg_any), 64'd1);
    tick();
    ctrl_cnt_clr = 1'b0;
    chk("clr_prio", 64'(trg_cnt), 64'd0);
    ticks(4);

    tot = pc[0] + pc[1] + pc[2] + pc[3];
    ctrl_trigger_type = 8'hFF;
    for (int t = 0; t < 3; t++) begin
      ext_trg_in = ~ext_trg_in;
      ticks(8);
    end
    ctrl_trigger_type = 8'h00;
    ctrl_enable = 4'h0;
    for (int t = 0; t < 3; t++) begin
      ext_trg_in = ~ext_trg_in;
      ticks(8);
    end
    ticks(4);
    chk("rsvd_dis", 64'(pc[0] + pc[1] + pc[2] + pc[3]), 64'(tot));

    ctrl_enable = 4'hF;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 6) == 0) ext_trg_in[c] = ~ext_trg_in[c];
      if ($urandom_range(0, 49) == 0) begin
        ctrl_enable = 4'($urandom);
        ctrl_trigger_type = 8'($urandom);
        ctrl_holdoff = 16'($urandom_range(0, 15));
      end
      ctrl_cnt_clr = ($urandom_range(0, 99) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
      tick();
      if (!rst_n) begin
        tick();
        rst_n = 1'b1;
      end
    end
    ctrl_cnt_clr = 1'b0;
    ticks(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
